mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit: the consumer of the EX/MEM pipeline register outputs.
- Turns a registered load/store into a req/ready data-memory transaction and stalls the pipeline until the transaction completes.
- Aligns, sign-extends or zero-extends load data, then presents writeback data and controls toward the MEM/WB register.

---
 rtl/mem_stage_lsu_pkg.sv | 30 +++
 rtl/load_align_ext.sv | 34 +++
 rtl/mem_stage_lsu.sv | 155 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   FUNC3_*     : load/store access encodings (stores use the low four)
//   lsu_state_e : access FSM states
//   strb_width  : byte-enable pattern for an access size, before lane shift
package mem_stage_lsu_pkg;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LD  = 3'b011;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_LWU = 3'b110;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } lsu_state_e;

    function automatic logic [7:0] strb_width(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data alignment: shifts the addressed lane of a read doubleword down to
// bit 0, then sign- or zero-extends it according to the access size.
//   rdata_in : doubleword returned by memory
//   off_in   : byte offset within the doubleword
//   func3_in : load size/sign encoding
//   data_out : register-ready load result
module load_align_ext
    import mem_stage_lsu_pkg::*;
(
    input  logic [63:0] rdata_in,
    input  logic [2:0]  off_in,
    input  logic [2:0]  func3_in,
    output logic [63:0] data_out
);

    logic [63:0] lane;

    assign lane = rdata_in >> {off_in, 3'b000};

    always_comb begin
        data_out = lane;
        case (func3_in)
            FUNC3_LB:  data_out = {{56{lane[7]}}, lane[7:0]};
            FUNC3_LH:  data_out = {{48{lane[15]}}, lane[15:0]};
            FUNC3_LW:  data_out = {{32{lane[31]}}, lane[31:0]};
            FUNC3_LD:  data_out = lane;
            FUNC3_LBU: data_out = {56'd0, lane[7:0]};
            FUNC3_LHU: data_out = {48'd0, lane[15:0]};
            FUNC3_LWU: data_out = {32'd0, lane[31:0]};
            default:   data_out = lane;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Turns the EX/MEM load/store into a held
// req/ready bus transaction, stalls the pipeline until it completes, and
// presents aligned writeback data toward MEM/WB.
//   clk, reset_n          : clock, asynchronous active-low reset
//   *_in                  : EX/MEM register outputs (func3, address/ALU result,
//                           store data, rd, controls)
//   dmem_*                : data-memory request/response
//   stall                 : freezes PC, IF/ID, ID/EX, EX/MEM
//   wb_data, rd_out,
//   reg_write_out         : toward MEM/WB
//   misalign_fault        : illegal/misaligned access (same cycle)
//   bus_error             : access timed out (pulses in DONE)
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned XLEN           = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      func3_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] alu_input2_in,
    input  logic [4:0]      rd_in,
    input  logic            RegWrite_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic            MemReg_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      rd_out,
    output logic            reg_write_out,
    output logic            misalign_fault,
    output logic            bus_error
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, wdata_q, load_q;
    logic [7:0]      wstrb_q;
    logic [2:0]      func3_q, off_q;
    logic            we_q, berr_q;
    logic [CntW-1:0] cnt_q;

    logic            mem_op, misaligned, legal, start, timeout;
    logic [2:0]      off;
    logic [1:0]      size;
    logic [XLEN-1:0] load_aligned;

    assign mem_op = MemRead_in | MemWrite_in;
    assign off    = alu_result_in[2:0];
    assign size   = func3_in[1:0];

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            2'd3:    misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    end

    assign legal = ~(MemRead_in & MemWrite_in)
                 & ~(MemWrite_in & func3_in[2])
                 & ~(MemRead_in & (func3_in == 3'b111))
                 & ~misaligned;

    assign start = (state_q == StIdle) & mem_op & legal;
    // ready on the final counted cycle takes priority over the timeout
    assign timeout = (state_q == StAccess) & ~dmem_ready
                   & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    load_align_ext u_align (
        .rdata_in (dmem_rdata),
        .off_in   (off_q),
        .func3_in (func3_q),
        .data_out (load_aligned)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StAccess;
            StAccess: if (dmem_ready || timeout) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Access datapath: request fields latched on entry, held through ACCESS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            func3_q <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
            berr_q  <= 1'b0;
        end else begin
            berr_q <= timeout;
            if (start) begin
                addr_q  <= {alu_result_in[XLEN-1:3], 3'b000};
                wdata_q <= alu_input2_in << {off, 3'b000};
                wstrb_q <= strb_width(size) << off;
                we_q    <= MemWrite_in;
                func3_q <= func3_in;
                off_q   <= off;
                cnt_q   <= '0;
            end else if (state_q == StAccess) begin
                if (dmem_ready) begin
                    load_q <= load_aligned;
                end else if (timeout) begin
                    load_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

    // Outputs
    always_comb begin
        dmem_req       = (state_q == StAccess);
        dmem_we        = dmem_req & we_q;
        dmem_wstrb     = dmem_req ? wstrb_q : 8'h00;
        dmem_addr      = addr_q;
        dmem_wdata     = wdata_q;
        stall          = start | (state_q == StAccess);
        misalign_fault = (state_q == StIdle) & mem_op & ~legal;
        bus_error      = berr_q;
        wb_data        = MemReg_in ? load_q : alu_result_in;
        rd_out         = rd_in;
        reg_write_out  = RegWrite_in & ~misalign_fault & ~berr_q;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int TMO = 4;

    logic        clk, reset_n;
    logic [2:0]  func3_in;
    logic [63:0] alu_result_in, alu_input2_in;
    logic [4:0]  rd_in;
    logic        RegWrite_in, MemRead_in, MemWrite_in, MemReg_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;
    logic        stall, reg_write_out, misalign_fault, bus_error;
    logic [63:0] wb_data;
    logic [4:0]  rd_out;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO), .XLEN(64)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .func3_in       (func3_in),
        .alu_result_in  (alu_result_in),
        .alu_input2_in  (alu_input2_in),
        .rd_in          (rd_in),
        .RegWrite_in    (RegWrite_in),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .MemReg_in      (MemReg_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .stall          (stall),
        .wb_data        (wb_data),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .misalign_fault (misalign_fault),
        .bus_error      (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] wb;
        logic        chk_wb;
        logic        rw;
        logic [4:0]  rd;
        logic        fault;
        logic        berr;
        int          stalls;
        logic        has_req;
        logic [63:0] raddr;
        logic        we;
        logic [7:0]  strb;
        logic [63:0] rs2;
        int          off;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  ref_mem[longint];
    logic [7:0]  bus_mem[longint];
    int          checks = 0;
    int          errors = 0;
    int          resp_wait = -2;
    logic        tb_valid = 1'b0;

    function automatic logic [7:0] init_byte(longint a);
        return 8'(a * 29 + 59);
    endfunction

    function automatic logic [7:0] ref_rd(longint a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] bus_rd(longint a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_byte(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload_dw(input longint a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            ref_mem[a + i] = v[8*i +: 8];
            bus_mem[a + i] = v[8*i +: 8];
        end
    endtask

    // Memory responder: `resp_wait` wait cycles then one ready; -1 = never.
    // Outside a request, ready/rdata toggle randomly and must be ignored.
    initial begin
        logic [63:0] d;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (dmem_req === 1'b1) begin
                if (resp_wait > 0) begin
                    resp_wait--;
                    dmem_ready = 1'b0;
                end else if (resp_wait == 0) begin
                    for (int i = 0; i < 8; i++) d[8*i +: 8] = bus_rd(longint'(dmem_addr) + i);
                    dmem_rdata = d;
                    dmem_ready = 1'b1;
                    if (dmem_we)
                        for (int i = 0; i < 8; i++)
                            if (dmem_wstrb[i]) bus_mem[longint'(dmem_addr) + i] = dmem_wdata[8*i +: 8];
                    resp_wait = -2;
                end else begin
                    dmem_ready = 1'b0;
                end
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor: checks bus requests against the in-flight expectation and
    // pops/compares the writeback side when the instruction retires.
    initial begin
        exp_t e;
        int   stall_cnt;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!(reset_n && tb_valid)) begin
                stall_cnt = 0;
            end else if (sb_q.size() > 0) begin
                e = sb_q[0];
                if (dmem_req) begin
                    check("req_allowed", 64'(e.has_req), 64'd1);
                    if (e.has_req) begin
                        check("req_addr", dmem_addr, e.raddr);
                        check("req_we", 64'(dmem_we), 64'(e.we));
                        check("req_strb", 64'(dmem_wstrb), 64'(e.strb));
                        for (int i = 0; i < 8; i++)
                            if (e.we && e.strb[i])
                                check("req_wdata_lane", 64'(dmem_wdata[8*i +: 8]),
                                      64'(e.rs2[8*(i - e.off) +: 8]));
                    end
                end
                if (stall) begin
                    stall_cnt++;
                    check("flags_while_stalled", {62'd0, misalign_fault, bus_error}, 64'd0);
                end else begin
                    void'(sb_q.pop_front());
                    check("rd_out", 64'(rd_out), 64'(e.rd));
                    check("reg_write_out", 64'(reg_write_out), 64'(e.rw));
                    check("misalign_fault", 64'(misalign_fault), 64'(e.fault));
                    check("bus_error", 64'(bus_error), 64'(e.berr));
                    check("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
                    if (e.chk_wb) check("wb_data", wb_data, e.wb);
                    stall_cnt = 0;
                end
            end
        end
    end

    // Drive one EX/MEM instruction, push its expected outcome, wait for retire.
    task automatic issue(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic mreg, input int wt);
        exp_t        e;
        int          bytes, off, n;
        logic        mem, illegal, to;
        logic [63:0] val;
        mem     = mr | mw;
        bytes   = 1 << f3[1:0];
        off     = int'(addr % 8);
        illegal = mem && ((mr && mw) || (mw && f3 > 3) || (mr && f3 == 7) || (addr % bytes != 0));
        to      = (wt < 0);
        e = '{wb: addr, chk_wb: 1'b1, rw: rw, rd: rd, fault: 1'b0, berr: 1'b0, stalls: 0,
              has_req: 1'b0, raddr: '0, we: 1'b0, strb: '0, rs2: rs2, off: off};
        if (mem && illegal) begin
            e.fault  = 1'b1;
            e.rw     = 1'b0;
            e.chk_wb = !mreg;
        end else if (mem) begin
            e.has_req = 1'b1;
            e.raddr   = addr & ~64'h7;
            e.we      = mw;
            e.strb    = 8'(((1 << bytes) - 1) << off);
            e.stalls  = to ? 1 + TMO : 2 + wt;
            e.berr    = to;
            if (to) e.rw = 1'b0;
            if (mr) begin
                val = '0;
                for (int i = 0; i < bytes; i++) val |= 64'(ref_rd(longint'(addr) + i)) << (8 * i);
                if (!f3[2] && bytes < 8 && val[8*bytes-1]) val |= ~64'd0 << (8 * bytes);
                if (to) val = '0;
                if (mreg) e.wb = val;
            end else if (!to) begin
                for (int i = 0; i < bytes; i++) ref_mem[longint'(addr) + i] = rs2[8*i +: 8];
            end
        end
        sb_q.push_back(e);
        resp_wait     = wt;
        func3_in      = f3;
        alu_result_in = addr;
        alu_input2_in = rs2;
        rd_in         = rd;
        RegWrite_in   = rw;
        MemRead_in    = mr;
        MemWrite_in   = mw;
        MemReg_in     = mreg;
        tb_valid      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall !== 1'b0 && n < 50);
        if (stall !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL retire_timeout actual=stall_after_%0d_cycles expected=retire", n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          kind, bytes, wt;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic        mr, mw;

        reset_n       = 1'b0;
        func3_in      = '0;
        alu_result_in = 64'h1234;
        alu_input2_in = '0;
        rd_in         = '0;
        RegWrite_in   = 1'b0;
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        MemReg_in     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 64'(dmem_req), 64'd0);
        check("rst_we", 64'(dmem_we), 64'd0);
        check("rst_wstrb", 64'(dmem_wstrb), 64'd0);
        check("rst_addr", dmem_addr, 64'd0);
        check("rst_wdata", dmem_wdata, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_bus_error", 64'(bus_error), 64'd0);
        check("rst_misalign", 64'(misalign_fault), 64'd0);
        check("rst_passthrough", wb_data, 64'h1234);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed cases
        preload_dw(64'h1000, 64'h8000_0001_1234_5678);
        issue(3'b010, 64'h1004, 64'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 0);    // LW
        issue(3'b000, 64'h2003, 64'hAB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3);   // SB
        issue(3'b100, 64'h2003, 64'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1);    // LBU readback
        issue(3'b001, 64'h3001, 64'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 0);    // LH misaligned
        issue(3'b011, 64'h4000, 64'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, -1);   // LD timeout
        preload_dw(64'h10, 64'h1122_3344_5566_77F0);
        issue(3'b100, 64'h10, 64'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 0);     // LBU
        issue(3'b000, 64'h55, 64'h0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 0);     // ADD

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 9);
            mr   = (kind >= 3 && kind <= 5) || kind == 9;
            mw   = (kind >= 6);
            if (kind >= 6 && kind <= 8) f3 = 3'($urandom_range(0, 4));
            else                        f3 = 3'($urandom_range(0, 7));
            bytes = 1 << f3[1:0];
            if (mr || mw) begin
                addr = 64'($urandom_range(0, 31) * 8);
                if ($urandom_range(0, 3) == 0) addr += 64'($urandom_range(0, 7));
                else                           addr += 64'($urandom_range(0, 7) & ~(bytes - 1));
            end else begin
                addr = {$urandom, $urandom};
            end
            wt = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            issue(f3, addr, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  mw && !mr ? 1'b0 : 1'($urandom_range(0, 1)), mr, mw, mr, wt);
        end

        // Asynchronous reset in the middle of an access
        tb_valid      = 1'b0;
        resp_wait     = -1;
        func3_in      = 3'b011;
        alu_result_in = 64'h80;
        RegWrite_in   = 1'b1;
        MemRead_in    = 1'b1;
        MemWrite_in   = 1'b0;
        MemReg_in     = 1'b1;
        for (int n = 0; n < 10 && dmem_req !== 1'b1; n++) @(negedge clk);
        check("pre_reset_req", 64'(dmem_req), 64'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_req", 64'(dmem_req), 64'd0);
        check("async_rst_wstrb", 64'(dmem_wstrb), 64'd0);
        check("async_rst_addr", dmem_addr, 64'd0);
        check("async_rst_bus_error", 64'(bus_error), 64'd0);
        MemRead_in  = 1'b0;
        RegWrite_in = 1'b0;
        MemReg_in   = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("post_rst_no_req", {62'd0, dmem_req, stall}, 64'd0);
        end

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
